sdram_wr_dma_ctrl: RTL and testbench

SDRAM_WR_DMA_CTRL -- requirements
Module: sdram_wr_dma_ctrl

---
 rtl/sdram_wr_dma_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sdram_wr_dma_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wr_dma_ctrl.sv
// rtl/sdram_wr_dma_ctrl.sv - write DMA engine issuing aligned Avalon-MM write bursts to SDRAM
//
// Writes len_i 128-bit words starting at base_addr_i as a series of bursts.
// No burst crosses a MAX_BURST-aligned boundary, and bursts are never
// truncated once issued. The payload is a generated pattern {~n, n}, where
// n is the 64-bit index of the beat within the transfer.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, abort_i      control strobes (start is ignored while busy)
//   base_addr_i, len_i    transfer setup, sampled when start is accepted
//   busy_o, done_o        status; done_o is a one-cycle IRQ pulse
//   aborted_o             the last transfer was ended by abort
//   cycle_cnt_o           busy cycles of the last or current transfer
//   avm_*                 Avalon-MM burst write master
module sdram_wr_dma_ctrl #(
  parameter int ADDR_W    = 28,
  parameter int MAX_BURST = 8,
  parameter int LEN_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [LEN_W-1:0]  cycle_cnt_o,
  output logic [ADDR_W-1:0] avm_address_o,
  output logic [7:0]        avm_burstcount_o,
  output logic              avm_write_o,
  output logic [127:0]      avm_writedata_o,
  output logic [15:0]       avm_byteenable_o,
  input  logic              avm_waitrequest_i
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BURST, S_FIN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    rem_q;
  logic [7:0]          beats_left_q;
  logic [63:0]         beat_cnt_q;
  logic                abort_pend_q;
  logic                busy_q;
  logic                done_q;
  logic                aborted_q;
  logic [LEN_W-1:0]    cycle_cnt_q;
  logic [ADDR_W-1:0]   avm_address_q;
  logic [7:0]          avm_burstcount_q;
  logic                avm_write_q;
  logic [127:0]        avm_writedata_q;

  logic [7:0]          room_d;
  logic [7:0]          blen_d;
  logic [63:0]         beat_inc_d;
  logic                abort_now_d;
  logic                last_beat_d;
  logic                xfer_end_d;

  always_comb begin
    // Beats left before the next MAX_BURST-aligned boundary; never exceeds
    // MAX_BURST, so min(MAX_BURST, rem, room) reduces to min(rem, room).
    room_d      = 8'(MAX_BURST) - 8'(addr_q & ADDR_W'(MAX_BURST - 1));
    blen_d      = (rem_q < LEN_W'(room_d)) ? rem_q[7:0] : room_d;
    beat_inc_d  = beat_cnt_q + 64'd1;
    // An abort strobe in the deciding cycle counts as already pending.
    abort_now_d = abort_pend_q | abort_i;
    last_beat_d = (beats_left_q == 8'd1);
    xfer_end_d  = (rem_q == LEN_W'(avm_burstcount_q)) || abort_now_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= S_IDLE;
      addr_q           <= '0;
      rem_q            <= '0;
      beats_left_q     <= '0;
      beat_cnt_q       <= '0;
      abort_pend_q     <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      aborted_q        <= 1'b0;
      cycle_cnt_q      <= '0;
      avm_address_q    <= '0;
      avm_burstcount_q <= '0;
      avm_write_q      <= 1'b0;
      avm_writedata_q  <= '0;
    end else begin
      if (busy_q) cycle_cnt_q <= cycle_cnt_q + LEN_W'(1);
      if (busy_q && abort_i) abort_pend_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            addr_q          <= base_addr_i;
            rem_q           <= len_i;
            beat_cnt_q      <= '0;
            avm_writedata_q <= {~64'd0, 64'd0};
            abort_pend_q    <= 1'b0;
            aborted_q       <= 1'b0;
            cycle_cnt_q     <= '0;
            busy_q          <= 1'b1;
            state_q         <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (rem_q == '0 || abort_now_d) begin
            aborted_q <= abort_now_d;
            done_q    <= 1'b1;
            state_q   <= S_FIN;
          end else begin
            avm_address_q    <= addr_q;
            avm_burstcount_q <= blen_d;
            beats_left_q     <= blen_d;
            avm_write_q      <= 1'b1;
            state_q          <= S_BURST;
          end
        end
        S_BURST: begin
          if (!avm_waitrequest_i) begin
            beat_cnt_q      <= beat_inc_d;
            avm_writedata_q <= {~beat_inc_d, beat_inc_d};
            if (last_beat_d) begin
              addr_q      <= addr_q + ADDR_W'(avm_burstcount_q);
              rem_q       <= rem_q - LEN_W'(avm_burstcount_q);
              avm_write_q <= 1'b0;
              if (xfer_end_d) begin
                aborted_q <= abort_now_d;
                done_q    <= 1'b1;
                state_q   <= S_FIN;
              end else begin
                state_q <= S_LOAD;
              end
            end else begin
              beats_left_q <= beats_left_q - 8'd1;
            end
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign aborted_o        = aborted_q;
  assign cycle_cnt_o      = cycle_cnt_q;
  assign avm_address_o    = avm_address_q;
  assign avm_burstcount_o = avm_burstcount_q;
  assign avm_write_o      = avm_write_q;
  assign avm_writedata_o  = avm_writedata_q;
  assign avm_byteenable_o = 16'hFFFF;

endmodule

// File: tb/tb_sdram_wr_dma_ctrl.sv
// tb/tb_sdram_wr_dma_ctrl.sv - scoreboard testbench for sdram_wr_dma_ctrl
module tb_sdram_wr_dma_ctrl;
  localparam int ADDR_W = 28;
  localparam int LEN_W  = 32;
  localparam int MB     = 8;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic [LEN_W-1:0]  len_i = '0;
  logic              busy_o, done_o, aborted_o;
  logic [LEN_W-1:0]  cycle_cnt_o;
  logic [ADDR_W-1:0] avm_address_o;
  logic [7:0]        avm_burstcount_o;
  logic              avm_write_o;
  logic [127:0]      avm_writedata_o;
  logic [15:0]       avm_byteenable_o;
  logic              avm_waitrequest_i = 1'b0;

  sdram_wr_dma_ctrl #(.ADDR_W(ADDR_W), .MAX_BURST(MB), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .base_addr_i(base_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .aborted_o(aborted_o), .cycle_cnt_o(cycle_cnt_o), .avm_address_o(avm_address_o),
    .avm_burstcount_o(avm_burstcount_o), .avm_write_o(avm_write_o),
    .avm_writedata_o(avm_writedata_o), .avm_byteenable_o(avm_byteenable_o),
    .avm_waitrequest_i(avm_waitrequest_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [7:0]        bc;
    logic [127:0]      d;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    beats_seen = 0;
  int    done_cnt = 0;
  bit    stall_en = 1'b0;

  // Slave model: optional stall on every other cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) avm_waitrequest_i = ~avm_waitrequest_i;
      else avm_waitrequest_i = 1'b0;
    end
  end

  // Monitor: every accepted beat is popped from the scoreboard and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (done_o === 1'b1) done_cnt++;
      if (avm_write_o === 1'b1 && avm_waitrequest_i === 1'b0) begin
        beat_t e;
        beats_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got addr=%h bc=%0d data=%h, required no beat",
                   avm_address_o, avm_burstcount_o, avm_writedata_o);
        end else begin
          e = exp_q.pop_front();
          if (avm_address_o !== e.a || avm_burstcount_o !== e.bc || avm_writedata_o !== e.d) begin
            errors++;
            $display("FAIL beat_%0d: got addr=%h bc=%0d data=%h, required addr=%h bc=%0d data=%h",
                     beats_seen - 1, avm_address_o, avm_burstcount_o, avm_writedata_o,
                     e.a, e.bc, e.d);
          end
        end
      end
    end
  end

  // Reference burst split: min(MB, rem, room to aligned boundary), data {~n, n}.
  task automatic push_model(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                            input int max_bursts);
    logic [ADDR_W-1:0] a = base;
    logic [LEN_W-1:0]  rem = len;
    logic [63:0]       n = '0;
    int                nb = 0;
    while (rem != 0 && nb < max_bursts) begin
      int bl;
      bl = MB - int'(a % MB);
      if (rem < LEN_W'(bl)) bl = int'(rem);
      for (int i = 0; i < bl; i++) begin
        beat_t e;
        e.a = a;
        e.bc = 8'(bl);
        e.d = {~n, n};
        exp_q.push_back(e);
        n++;
      end
      a = a + ADDR_W'(bl);
      rem = rem - LEN_W'(bl);
      nb++;
    end
  endtask

  task automatic kick(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l, input bit ab);
    @(posedge clk);
    #1;
    base_addr_i = b;
    len_i = l;
    start_i = 1'b1;
    abort_i = ab;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  // Latency counted in edges, the edge that samples start being 1.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 2; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (done_o === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", done_o); end
    checks++; if (aborted_o !== 1'b0) begin errors++; $display("FAIL rst_aborted: got %b, required 0", aborted_o); end
    checks++; if (cycle_cnt_o !== '0) begin errors++; $display("FAIL rst_cycle_cnt: got %0d, required 0", cycle_cnt_o); end
    checks++; if (avm_write_o !== 1'b0) begin errors++; $display("FAIL rst_write: got %b, required 0", avm_write_o); end
    checks++; if (avm_address_o !== '0) begin errors++; $display("FAIL rst_address: got %h, required 0", avm_address_o); end
    checks++; if (avm_burstcount_o !== 8'd0) begin errors++; $display("FAIL rst_burstcount: got %0d, required 0", avm_burstcount_o); end
    checks++; if (avm_writedata_o !== '0) begin errors++; $display("FAIL rst_writedata: got %h, required 0", avm_writedata_o); end
    checks++; if (avm_byteenable_o !== 16'hFFFF) begin errors++; $display("FAIL rst_byteenable: got %h, required ffff", avm_byteenable_o); end
    rst_i = 1'b0;
  endtask

  task automatic run_xfer(input string nm, input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l,
                          input int exp_lat, input int exp_beats);
    int lat;
    done_cnt = 0;
    beats_seen = 0;
    push_model(b, l, 1000);
    kick(b, l, 1'b0);
    wait_done(lat);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s_latency: got %0d, required %0d", nm, lat, exp_lat); end
    checks++; if (cycle_cnt_o !== LEN_W'(exp_lat)) begin errors++; $display("FAIL %s_cycle_cnt: got %0d, required %0d", nm, cycle_cnt_o, exp_lat); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done_pulses: got %0d, required 1", nm, done_cnt); end
    checks++; if (aborted_o !== 1'b0) begin errors++; $display("FAIL %s_aborted: got %b, required 0", nm, aborted_o); end
    checks++; if (beats_seen != exp_beats) begin errors++; $display("FAIL %s_beats: got %0d, required %0d", nm, beats_seen, exp_beats); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s_missing_beats: got %0d left, required 0", nm, exp_q.size()); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL %s_busy_after: got %b, required 0", nm, busy_o); end
    exp_q.delete();
  endtask

  task automatic test_two_bursts;
    run_xfer("two_bursts", 28'h100, 32'd16, 19, 16);
  endtask

  task automatic test_boundary_split;
    run_xfer("boundary", 28'h106, 32'd5, 8, 5);
  endtask

  task automatic test_len_zero;
    run_xfer("len_zero", 28'h040, 32'd0, 2, 0);
  endtask

  task automatic test_abort_stall;
    int lat;
    done_cnt = 0;
    beats_seen = 0;
    stall_en = 1'b1;
    push_model(28'h0, 32'd32, 2);
    kick(28'h0, 32'd32, 1'b0);
    for (int i = 0; i < 200 && beats_seen < 10; i++) @(posedge clk);
    #1;
    checks++; if (beats_seen < 10) begin errors++; $display("FAIL abort_reach_burst2: got %0d beats, required 10", beats_seen); end
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    wait_done(lat);
    stall_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (lat < 0) begin errors++; $display("FAIL abort_done_timeout: got none, required done pulse"); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL abort_done_pulses: got %0d, required 1", done_cnt); end
    checks++; if (aborted_o !== 1'b1) begin errors++; $display("FAIL abort_flag: got %b, required 1", aborted_o); end
    checks++; if (beats_seen != 16) begin errors++; $display("FAIL abort_beats: got %0d, required 16", beats_seen); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_missing_beats: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_start_with_abort;
    int lat;
    @(posedge clk);
    #1;
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_abort_busy: got %b, required 0", busy_o); end
    checks++; if (aborted_o !== 1'b1) begin errors++; $display("FAIL idle_abort_held: got %b, required 1", aborted_o); end
    done_cnt = 0;
    beats_seen = 0;
    push_model(28'h3, 32'd3, 1000);
    kick(28'h3, 32'd3, 1'b1);
    checks++; if (aborted_o !== 1'b0) begin errors++; $display("FAIL start_clears_aborted: got %b, required 0", aborted_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL start_abort_busy: got %b, required 1", busy_o); end
    wait_done(lat);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (lat != 5) begin errors++; $display("FAIL start_abort_latency: got %0d, required 5", lat); end
    checks++; if (aborted_o !== 1'b0) begin errors++; $display("FAIL start_abort_flag: got %b, required 0", aborted_o); end
    checks++; if (beats_seen != 3) begin errors++; $display("FAIL start_abort_beats: got %0d, required 3", beats_seen); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL start_abort_missing: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_busy_start_and_reset;
    done_cnt = 0;
    beats_seen = 0;
    push_model(28'h200, 32'd16, 1000);
    kick(28'h200, 32'd16, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    base_addr_i = 28'h300;
    len_i = 32'd4;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int i = 0; i < 100 && beats_seen < 10; i++) @(posedge clk);
    #1;
    checks++; if (beats_seen < 10) begin errors++; $display("FAIL midrst_progress: got %0d beats, required 10", beats_seen); end
    checks++; if (avm_write_o !== 1'b1) begin errors++; $display("FAIL midrst_in_burst: got %b, required 1", avm_write_o); end
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    checks++; if (avm_write_o !== 1'b0) begin errors++; $display("FAIL midrst_write: got %b, required 0", avm_write_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy_o); end
    checks++; if (cycle_cnt_o !== '0) begin errors++; $display("FAIL midrst_cycle_cnt: got %0d, required 0", cycle_cnt_o); end
    checks++; if (avm_address_o !== '0 || avm_burstcount_o !== 8'd0 || avm_writedata_o !== '0) begin
      errors++;
      $display("FAIL midrst_avm: got addr=%h bc=%0d data=%h, required all 0", avm_address_o, avm_burstcount_o, avm_writedata_o);
    end
    checks++; if (aborted_o !== 1'b0) begin errors++; $display("FAIL midrst_aborted: got %b, required 0", aborted_o); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL midrst_done: got %0d pulses, required 0", done_cnt); end
    checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL midrst_idle: got done=%b busy=%b, required 0 0", done_o, busy_o); end
    exp_q.delete();
  endtask

  task automatic test_recovery;
    run_xfer("recovery", 28'h7, 32'd1, 3, 1);
  endtask

  initial begin
    test_reset();
    test_two_bursts();
    test_boundary_split();
    test_len_zero();
    test_abort_stall();
    test_start_with_abort();
    test_busy_start_and_reset();
    test_recovery();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
